// File: rtl/dm_store_logger.sv
// dm_store_logger
// ----------------
// Store-trace buffer for the data-memory port of the pipelined core. Every
// cycle with DM_writeEnable high, the store {DM_addr, DM_writeData, ts} goes
// into a circular FIFO. A host consumer drains the FIFO head. When the FIFO is
// full, a store is dropped, counted and flagged. The processor is never
// stalled.
//
// Handshake: out_valid is high whenever the FIFO holds at least one entry.
// The head entry transfers on any rising edge where out_valid and out_ready
// are both high. out_valid never depends on out_ready. out_ready only changes
// state at the next edge. The head fields are first-word-fall-through and
// stay stable until they are popped.
//
// Ports:
//   CLOCK_50        single clock, rising edge
//   reset           asynchronous active-low reset
//   DM_writeEnable  store strobe, one store per high cycle
//   DM_addr         store byte address (N bits)
//   DM_writeData    store data (N bits)
//   clear           synchronous flush of FIFO, drop counter and overflow flag
//   out_ready       consumer accepts the head entry this cycle
//   out_valid       head entry present
//   out_addr        head entry address
//   out_data        head entry data
//   out_ts          head entry timestamp
//   count           occupancy, 0..DEPTH
//   drop_count      saturating count of dropped stores
//   overflow        sticky, set by any dropped store
//
// DEPTH must be a power of two and at least 2, so the pointers wrap by
// natural overflow.

module dm_store_logger #(
    parameter int N      = 64,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 32,
    parameter int DROP_W = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     DM_writeEnable,
    input  logic [N-1:0]             DM_addr,
    input  logic [N-1:0]             DM_writeData,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [N-1:0]             out_addr,
    output logic [N-1:0]             out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        drop_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * N + TS_W;

    typedef logic [CW-1:0] count_t;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [TS_W-1:0]   ts;
    logic [EW-1:0]     head;

    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    assign out_valid = (count != '0);
    assign full      = (count == count_t'(DEPTH));
    assign pop       = out_valid & out_ready & ~clear;
    // When the FIFO is full, a store is still accepted if the head leaves in
    // the same cycle.
    assign push_ok   = DM_writeEnable & ~clear & (~full | pop);
    assign drop      = DM_writeEnable & ~clear & full & ~pop;

    // The head fields are gated with out_valid. They read 0 after reset or
    // after a flush, even though the storage array is not reset.
    assign head     = mem[rd_ptr];
    assign out_addr = out_valid ? head[EW-1 -: N]     : '0;
    assign out_data = out_valid ? head[TS_W +: N]     : '0;
    assign out_ts   = out_valid ? head[TS_W-1:0]      : '0;

    // The free-running timestamp ignores clear.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // The storage array holds data only, so it has no reset.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem[wr_ptr] <= {DM_addr, DM_writeData, ts};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + count_t'(1);
                2'b01:   count <= count - count_t'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_store_logger.sv
// Testbench for dm_store_logger. A queue-based reference model is checked on
// every falling edge. Directed scenarios also check hand-computed values.
// DROP_W is reduced to 3 so that the saturation of drop_count can be reached.

module tb_dm_store_logger;

  localparam int N      = 64;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 32;
  localparam int DROP_W = 3;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int EW     = 2 * N + TS_W;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [N-1:0]      addr;
  logic [N-1:0]      wdata;
  logic              clear;
  logic              out_ready;
  logic              out_valid;
  logic [N-1:0]      out_addr;
  logic [N-1:0]      out_data;
  logic [TS_W-1:0]   out_ts;
  logic [CW-1:0]     count;
  logic [DROP_W-1:0] drop_count;
  logic              overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  dm_store_logger #(
    .N(N), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst_n),
    .DM_writeEnable(we),
    .DM_addr(addr),
    .DM_writeData(wdata),
    .clear(clear),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_addr(out_addr),
    .out_data(out_data),
    .out_ts(out_ts),
    .count(count),
    .drop_count(drop_count),
    .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [EW-1:0]     exp_q[$];
  logic [TS_W-1:0]   m_ts;
  int                m_drops;
  logic              m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ts    <= '0;
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      if (clear) begin
        exp_q.delete();
        m_drops = 0;
        m_ovf   = 1'b0;
      end else begin
        bit do_pop;
        do_pop = (exp_q.size() > 0) && out_ready;
        if (do_pop) void'(exp_q.pop_front());
        if (we) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back({addr, wdata, m_ts});
          end else begin
            m_ovf = 1'b1;
            if (m_drops < int'(DROP_MAX)) m_drops++;
          end
        end
      end
      m_ts <= m_ts + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check("model_count", 64'(count), 64'(exp_q.size()));
      check("model_drops", 64'(drop_count), 64'(m_drops));
      check("model_ovf", 64'(overflow), 64'(m_ovf));
      if (exp_q.size() > 0) begin
        logic [EW-1:0] h;
        h = exp_q[0];
        check("model_addr", out_addr, h[EW-1 -: N]);
        check("model_data", out_data, h[TS_W +: N]);
        check("model_ts", 64'(out_ts), 64'(h[TS_W-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic w, input logic [N-1:0] a, input logic [N-1:0] d,
                       input logic rdy, input logic clr);
    we        = w;
    addr      = a;
    wdata     = d;
    out_ready = rdy;
    clear     = clr;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, rdy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_addr"}, out_addr, 64'd0);
    check({tag, "_data"}, out_data, 64'd0);
    check({tag, "_ts"}, 64'(out_ts), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_drops"}, 64'(drop_count), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    we = 1'b0; addr = '0; wdata = '0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset, then five idle cycles; the first store is sampled with ts=5.
    repeat (5) idle(1'b0);
    check_all_zero("idle");
    cycle(1'b1, 64'h40, 64'hDEAD, 1'b0, 1'b0);
    we = 1'b0;
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_addr", out_addr, 64'h40);
    check("t1_data", out_data, 64'hDEAD);
    check("t1_ts", 64'(out_ts), 64'd5);
    check("t1_count", 64'(count), 64'd1);
    idle(1'b1);
    check("t1_empty", 64'(count), 64'd0);

    // Fill past full with 18 stores: 16 are kept and 2 are dropped.
    for (int i = 1; i <= 18; i++) cycle(1'b1, 64'h1000 + 64'(8 * i), 64'(i), 1'b0, 1'b0);
    check("fill_count", 64'(count), 64'd16);
    check("fill_drops", 64'(drop_count), 64'd2);
    check("fill_ovf", 64'(overflow), 64'd1);
    check("fill_head", out_data, 64'd1);

    // Full FIFO with a pop and a push in the same cycle.
    cycle(1'b1, 64'h2000, 64'h99, 1'b1, 1'b0);
    check("fullpp_count", 64'(count), 64'd16);
    check("fullpp_drops", 64'(drop_count), 64'd2);

    // Drain: 2..16 come out in order, then 0x99.
    for (int i = 0; i < 16; i++) begin
      check("drain_data", out_data, (i < 15) ? 64'(i + 2) : 64'h99);
      idle(1'b1);
    end
    check("drain_empty", 64'(out_valid), 64'd0);

    // Streaming with out_ready held high: occupancy never exceeds 1.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 64'h3000 + 64'(i), 64'd100 + 64'(i), 1'b1, 1'b0);
      check("stream_count_le1", 64'(count <= 1), 64'd1);
    end
    idle(1'b1);
    check("stream_drops", 64'(drop_count), 64'd2);

    // Reach count=7 and drop_count=3, then clear together with a store.
    for (int i = 0; i < 17; i++) cycle(1'b1, 64'h4000 + 64'(i), 64'd200 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);
    check("pre_clear_count", 64'(count), 64'd7);
    check("pre_clear_drops", 64'(drop_count), 64'd3);
    cycle(1'b1, 64'h5000, 64'h77, 1'b0, 1'b1);
    check("clear_count", 64'(count), 64'd0);
    check("clear_valid", 64'(out_valid), 64'd0);
    check("clear_drops", 64'(drop_count), 64'd0);
    check("clear_ovf", 64'(overflow), 64'd0);
    idle(1'b0);
    check("clear_not_logged", 64'(out_valid), 64'd0);

    // drop_count saturates at its maximum and does not wrap.
    for (int i = 0; i < 26; i++) cycle(1'b1, 64'h6000 + 64'(i), 64'd300 + 64'(i), 1'b0, 1'b0);
    check("sat_drops", 64'(drop_count), 64'(DROP_MAX));
    check("sat_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 11; i++) idle(1'b1);
    idle(1'b0);
    check("pre_reset_count", 64'(count), 64'd5);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 64'h80, 64'h55, 1'b0, 1'b0);
    we = 1'b0;
    check("rst_ts_restart", 64'(out_ts), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd1);
    check("rst_data", out_data, 64'h55);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
